// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction
// memory under a credit limit, buffers returned words in a prefetch FIFO and
// hands {inst, inst_pc} to the decoder. Redirects and halt flush the FIFO and
// drop responses that were already in flight.
// Optional build macro: IFETCH_STATS_EN enables the fetch/redirect counters;
// when undefined both counter ports read 32'h0.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic [31:0] fetch_count,
  output logic [31:0] redirect_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     inst_mem_q [FIFO_DEPTH];
  logic [31:0]     inst_mem_d [FIFO_DEPTH];
  logic [31:0]     pc_mem_q   [FIFO_DEPTH];
  logic [31:0]     pc_mem_d   [FIFO_DEPTH];

  logic            run_s;
  logic [CW:0]     credit_sum_s;
  logic            req_valid_s;
  logic            req_fire_s;
  logic            push_s;
  logic            pop_s;
  logic            redir_take_s;
  logic [31:0]     redirect_tgt_s;

  // Request gating, handshake qualifiers and the aligned redirect target.
  always_comb begin
    run_s          = (state_q == ST_RUN);
    credit_sum_s   = {1'b0, count_q} + {1'b0, outstanding_q};
    // rst_n gates the request so nothing is offered while reset is held.
    req_valid_s    = rst_n && run_s && !halt && !redirect_valid &&
                     (credit_sum_s < DEPTH_C);
    req_fire_s     = req_valid_s && imem_req_ready;
    redir_take_s   = run_s && redirect_valid && !halt;
    push_s         = run_s && !halt && !redirect_valid && imem_rsp_valid &&
                     (discard_q == {CW{1'b0}});
    pop_s          = (count_q != {CW{1'b0}}) && inst_ready;
    redirect_tgt_s = redirect_pc & 32'hFFFF_FFFC;
  end

  // Next-state: FSM, PC tracking, stale-response accounting and FIFO update.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_d     = discard_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    inst_mem_d    = inst_mem_q;
    pc_mem_d      = pc_mem_q;
    // Every response retires the oldest request regardless of its fate.
    outstanding_d = outstanding_q + CW'(req_fire_s) - CW'(imem_rsp_valid);

    if (!run_s) begin
      // Halted: FIFO stays empty, late responses are simply absorbed.
      count_d   = {CW{1'b0}};
      discard_d = {CW{1'b0}};
    end else if (halt) begin
      state_d   = ST_HALTED;
      count_d   = {CW{1'b0}};
      wr_ptr_d  = {AW{1'b0}};
      rd_ptr_d  = {AW{1'b0}};
      discard_d = {CW{1'b0}};
    end else if (redirect_valid) begin
      // Whatever is still in flight after this cycle's response is stale.
      count_d    = {CW{1'b0}};
      wr_ptr_d   = {AW{1'b0}};
      rd_ptr_d   = {AW{1'b0}};
      fetch_pc_d = redirect_tgt_s;
      rsp_pc_d   = redirect_tgt_s;
      discard_d  = outstanding_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (imem_rsp_valid && (discard_q != {CW{1'b0}})) begin
        discard_d = discard_q - CW'(1'b1);
      end else begin
        discard_d = discard_q;
      end
      if (push_s) begin
        inst_mem_d[wr_ptr_q] = imem_rsp_data;
        pc_mem_d[wr_ptr_q]   = rsp_pc_q;
        wr_ptr_d             = wr_ptr_q + AW'(1'b1);
        rsp_pc_d             = rsp_pc_q + 32'd4;
      end else begin
        wr_ptr_d = wr_ptr_q;
        rsp_pc_d = rsp_pc_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= {CW{1'b0}};
      discard_q     <= {CW{1'b0}};
      count_q       <= {CW{1'b0}};
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        inst_mem_q[i] <= 32'h0;
        pc_mem_q[i]   <= 32'h0;
      end
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      inst_mem_q    <= inst_mem_d;
      pc_mem_q      <= pc_mem_d;
    end
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_q;
  assign inst_valid     = (count_q != {CW{1'b0}});
  assign inst           = inst_mem_q[rd_ptr_q];
  assign inst_pc        = pc_mem_q[rd_ptr_q];

`ifdef IFETCH_STATS_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] redirect_count_q, redirect_count_d;

  // Counter next-state: kept words and honoured redirects.
  always_comb begin
    fetch_count_d    = fetch_count_q;
    redirect_count_d = redirect_count_q;
    if (push_s) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end else begin
      fetch_count_d = fetch_count_q;
    end
    if (redir_take_s) begin
      redirect_count_d = redirect_count_q + 32'd1;
    end else begin
      redirect_count_d = redirect_count_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q    <= 32'h0;
      redirect_count_q <= 32'h0;
    end else begin
      fetch_count_q    <= fetch_count_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign fetch_count    = fetch_count_q;
  assign redirect_count = redirect_count_q;
`else
  logic unused_stats_s;
  assign unused_stats_s = redir_take_s;
  assign fetch_count    = 32'h0;
  assign redirect_count = 32'h0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch with a variable-latency in-order memory
// model that returns (address ^ KEY) as the instruction word.
module tb_inst_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
`ifdef IFETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b1;
  logic [31:0] fetch_count;
  logic [31:0] redirect_count;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .fetch_count    (fetch_count),
    .redirect_count (redirect_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Memory model: requests captured at the edge, response driven lat cycles later.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } rq_t;
  rq_t         pend[$];
  logic [31:0] acc_log[$];
  int          lat = 1;
  int          cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      acc_log.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end else begin
      cyc++;
      if (imem_req_valid && imem_req_ready) begin
        pend.push_back('{imem_req_addr, cyc + lat - 1});
        acc_log.push_back(imem_req_addr);
      end
      #1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend[0].addr ^ KEY;
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  end

  // Reset pulse; rst_n rises at a falling edge, starting "cycle 0".
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int found;
    int waited;
    int bad;
    int log_size;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check_eq("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_inst_pc", inst_pc, 32'h0);
    check_eq("rst_fetch_count", fetch_count, 32'h0);
    check_eq("rst_redirect_count", redirect_count, 32'h0);

    // Streaming with 1-cycle memory
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check_eq("first_req_addr", imem_req_addr, 32'h0000_3000);
    @(negedge clk);
    #1;
    check_eq("inst_valid_c1", {31'h0, inst_valid}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check_eq("stream_valid", {31'h0, inst_valid}, 32'h1);
      check_eq("stream_pc", inst_pc, 32'h0000_3000 + 32'(i * 4));
      check_eq("stream_inst", inst, (32'h0000_3000 + 32'(i * 4)) ^ KEY);
    end
    check_eq("stream_fetch_count", fetch_count, STATS ? 32'd8 : 32'd0);

    // Backpressure: credit limit of 4
    inst_ready = 1'b0;
    apply_reset();
    repeat (10) @(negedge clk);
    #1;
    check_eq("bp_accept_count", 32'(acc_log.size()), 32'd4);
    check_eq("bp_accept_last", (acc_log.size() >= 4) ? acc_log[3] : 32'hDEAD_DEAD, 32'h0000_300C);
    check_eq("bp_head_pc", inst_pc, 32'h0000_3000);
    @(negedge clk);
    inst_ready = 1'b1;
    #1;
    check_eq("bp_drain_pc0", inst_pc, 32'h0000_3000);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      #1;
      check_eq("bp_drain_pc", inst_pc, 32'h0000_3000 + 32'(i * 4));
    end
    check_eq("bp_resume_addr", (acc_log.size() >= 5) ? acc_log[4] : 32'hDEAD_DEAD, 32'h0000_3010);

    // Redirect with 3 stale responses in flight (3-cycle memory)
    lat = 3;
    apply_reset();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3401;
    #1;
    check_eq("redir_no_req", {31'h0, imem_req_valid}, 32'h0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check_eq("redir_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check_eq("redir_req_addr", imem_req_addr, 32'h0000_3400);
    check_eq("redir_flushed", {31'h0, inst_valid}, 32'h0);
    found = 0;
    waited = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      @(negedge clk);
      #1;
      waited++;
      if (inst_valid) found = 1;
    end
    check_eq("redir_seen", found, 32'd1);
    check_eq("redir_latency", waited, 32'd4);
    check_eq("redir_first_pc", inst_pc, 32'h0000_3400);
    check_eq("redir_first_inst", inst, 32'h0000_3400 ^ KEY);
    check_eq("redir_fetch_count", fetch_count, STATS ? 32'd1 : 32'd0);
    check_eq("redir_redirect_count", redirect_count, STATS ? 32'd1 : 32'd0);

    // Halt and redirect together: halt wins, fetch stops for good
    @(negedge clk);
    halt           = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_5000;
    #1;
    check_eq("halt_no_req", {31'h0, imem_req_valid}, 32'h0);
    log_size = acc_log.size();
    @(negedge clk);
    halt           = 1'b0;
    redirect_valid = 1'b0;
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (imem_req_valid || inst_valid) bad++;
      @(negedge clk);
    end
    check_eq("halt_quiet_cycles", bad, 32'd0);
    check_eq("halt_no_accepts", 32'(acc_log.size()), 32'(log_size));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_6000;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check_eq("halted_redir_req", {31'h0, imem_req_valid}, 32'h0);
    check_eq("halted_redir_valid", {31'h0, inst_valid}, 32'h0);
    check_eq("halted_redirect_count", redirect_count, STATS ? 32'd1 : 32'd0);

    // Request held stable under imem_req_ready=0, then reset mid-stream
    lat = 1;
    inst_ready = 1'b0;
    imem_req_ready = 1'b1;
    apply_reset();
    @(negedge clk);
    @(negedge clk);
    imem_req_ready = 1'b0;
    bad = 0;
    for (int n = 0; n < 5; n++) begin
      #1;
      if (!imem_req_valid || imem_req_addr !== 32'h0000_3008) bad++;
      @(negedge clk);
    end
    check_eq("stall_addr_stable", bad, 32'd0);
    check_eq("stall_addr", imem_req_addr, 32'h0000_3008);
    check_eq("stall_inst_valid", {31'h0, inst_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check_eq("midrst_inst_valid", {31'h0, inst_valid}, 32'h0);
    check_eq("midrst_inst", inst, 32'h0);
    check_eq("midrst_inst_pc", inst_pc, 32'h0);
    check_eq("midrst_req_addr", imem_req_addr, 32'h0000_3000);
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("restart_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check_eq("restart_req_addr", imem_req_addr, 32'h0000_3000);
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("restart_valid", {31'h0, inst_valid}, 32'h1);
    check_eq("restart_pc", inst_pc, 32'h0000_3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
